multi_timer: RTL and testbench
==============================

# multi_timer

Parametrised multi-channel timer for the XM-23 CPU, successor to the single-channel timer device. It provides CHANNELS independent down-period timers, each with its own CSR and DR, on one byte-wide register port. Each channel has a computed prescaler instead of a lookup table, plus one-shot mode and a per-channel interrupt request. It sits on the CPU device bus beside the other memory-mapped devices.

## Interface
- CHANNELS, 2, number of independent timer channels (1–8)
- PRE_SHIFT, 4, prescale exponent; channel period = (DR+1) << PRE_SHIFT clock cycles
- COUNT_WIDTH, 16, counter width; must be ≥ 8 + PRE_SHIFT
- AW, $clog2(2*CHANNELS), register address width (derived)

- clock  input  1  system clock, all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- wr_en  input  1  register write strobe, one cycle per write
- rd_en  input  1  register read strobe, one cycle per read
- addr  input  AW  register select: 2n = CSR of channel n, 2n+1 = DR of channel n
- wdata  input  8  write data
- rdata  output  8  registered read data
- irq  output  CHANNELS  per-channel interrupt request, irq[n] = CSR[n].IE & CSR[n].DBA

## Operation
- CSR bit map: [7:5] reserved, read 0; [4] ENA; [3] OF; [2] DBA; [1] ONESHOT; [0] IE.
- CSR write: ENA, ONESHOT and IE take wdata. DBA and OF can only be cleared by software: written 0 clears, written 1 leaves the bit unchanged.
- DR write: loads DR and clears the channel counter to 0.
- CSR write that takes ENA from 0 to 1: clears the counter to 0.
- Per-channel states: IDLE (ENA=0; counter held at 0) and RUN (ENA=1; counter increments every cycle).
- Terminal in RUN is count == ((DR+1) << PRE_SHIFT) − 1. At terminal:
  - counter ← 0, DBA ← 1;
  - OF ← 1 if DBA was already 1 before that edge;
  - if ONESHOT=1, ENA ← 0 and the channel moves to IDLE.
- Simultaneous terminal tick and software write on the same channel:
  - a tick set of DBA/OF wins over a software clear;
  - OF uses the pre-edge DBA value;
  - the written DR/ENA/IE/ONESHOT still take effect and the write clears the counter.
- Simultaneous terminal tick and a software ENA=1 write in ONESHOT mode: the written ENA wins and the counter restarts at 0.
- Arithmetic is unsigned, COUNT_WIDTH bits. Terminal compare is on the full width, with no wrap before terminal.
- Out-of-range addr (≥ 2*CHANNELS): writes ignored, reads return 0.
- Channels are fully independent; a write to one channel never affects another.

## Timing
- Reset (reset_n low, asynchronous): all CSR = 8'h00, all DR = 8'h00, all counters = 0, rdata = 8'h00, irq = 0. Channels resume at the first clock edge after release.
- Write latency: register value visible at the rising edge where wr_en is sampled.
- Read latency: 1 cycle. rdata is valid after the edge that samples rd_en and holds until the next read.
- Read of a register in the same cycle as a write to it returns the pre-write value.
- Enable-to-first-DBA: with ENA written at edge E0, DBA is set at edge E0 + (DR+1)<<PRE_SHIFT. The period between DBA events is the same.
- irq is derived only from registered CSR bits; there is no combinational path from any input.
- wr_en and rd_en asserted together: both are honoured.
- reset_n asserted mid-count: everything clears immediately, with no pending tick.

## Test plan
- Reset, then read CSR0, DR0, CSR1 and DR1 → each returns 8'h00; irq = 0.
- PRE_SHIFT=0: write DR0=3, then CSR0=8'h11 at edge E0 → DBA0 and irq[0] are 1 at E0+4. Write CSR0=8'h11 to clear DBA; DBA0 sets again at E0+8.
- Leave DBA0 uncleared for a second period → OF0 sets at E0+8; CSR0 reads 8'h1D.
- ONESHOT: write CSR1=8'h12 with DR1=1 → DBA1 at E0+2; ENA1 reads 0; no further events over 20 cycles; channel 0 unaffected.
- Software writes CSR0 with DBA=0 on the exact terminal edge → DBA0 reads 1, and OF0 reflects the prior DBA value.
- Assert reset_n low mid-count (count=2 of 4) → all registers and irq read 0; after release no DBA event occurs until re-enabled.

Source files
------------

// File: rtl/multi_timer.sv
// multi_timer: CHANNELS independent down-period timers on one byte-wide register port.
// Per channel: CSR {ENA, OF, DBA, ONESHOT, IE} at addr 2n and period DR at addr 2n+1.
module multi_timer #(
    parameter int CHANNELS    = 2,
    parameter int PRE_SHIFT   = 4,
    parameter int COUNT_WIDTH = 16,
    parameter int AW          = $clog2(2 * CHANNELS)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [AW-1:0]       addr,
    input  logic [7:0]          wdata,
    output logic [7:0]          rdata,
    output logic [CHANNELS-1:0] irq
);

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    logic [7:0] csr_v [CHANNELS];
    logic [7:0] dr_v  [CHANNELS];
    logic [7:0] rdata_q, rdata_d;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic                   ena_q, ena_d;
        logic                   of_q, of_d;
        logic                   dba_q, dba_d;
        logic                   one_q, one_d;
        logic                   ie_q, ie_d;
        logic [7:0]             dr_q, dr_d;
        logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
        logic [COUNT_WIDTH-1:0] term;
        logic                   wr_csr, wr_dr, tick;

        always_comb begin
            wr_csr = wr_en && (addr == AW'(2 * g));
            wr_dr  = wr_en && (addr == AW'(2 * g + 1));
            term   = ((COUNT_WIDTH'(dr_q) + CNT_ONE) << PRE_SHIFT) - CNT_ONE;
            tick   = ena_q && (cnt_q == term);

            ena_d = ena_q;
            of_d  = of_q;
            dba_d = dba_q;
            one_d = one_q;
            ie_d  = ie_q;
            dr_d  = dr_q;

            if (tick && one_q) ena_d = 1'b0;
            if (wr_csr) begin
                ena_d = wdata[4];
                one_d = wdata[1];
                ie_d  = wdata[0];
                if (!wdata[3]) of_d  = 1'b0;
                if (!wdata[2]) dba_d = 1'b0;
            end
            if (wr_dr) dr_d = wdata;
            // Tick sets beat a same-edge software clear; OF looks at pre-edge DBA.
            if (tick) begin
                dba_d = 1'b1;
                if (dba_q) of_d = 1'b1;
            end

            cnt_d = cnt_q + CNT_ONE;
            if (tick || wr_dr || (wr_csr && wdata[4] && !ena_q) || !ena_d)
                cnt_d = '0;
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                ena_q <= 1'b0;
                of_q  <= 1'b0;
                dba_q <= 1'b0;
                one_q <= 1'b0;
                ie_q  <= 1'b0;
                dr_q  <= 8'h00;
                cnt_q <= '0;
            end else begin
                ena_q <= ena_d;
                of_q  <= of_d;
                dba_q <= dba_d;
                one_q <= one_d;
                ie_q  <= ie_d;
                dr_q  <= dr_d;
                cnt_q <= cnt_d;
            end
        end

        assign irq[g]   = ie_q & dba_q;
        assign csr_v[g] = {3'b000, ena_q, of_q, dba_q, one_q, ie_q};
        assign dr_v[g]  = dr_q;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = 8'h00;
            for (int n = 0; n < CHANNELS; n++) begin
                if (addr == AW'(2 * n))     rdata_d = csr_v[n];
                if (addr == AW'(2 * n + 1)) rdata_d = dr_v[n];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rdata_q <= 8'h00;
        else          rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer: directed scenarios plus random register traffic,
// checked against a cycle-timestamp reference model.
module tb_multi_timer;

    localparam int CH = 3;
    localparam int PS = 0;
    localparam int CW = 16;
    localparam int AW = 3;

    logic          clock;
    logic          reset_n;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic [7:0]    rdata;
    logic [CH-1:0] irq;

    multi_timer #(
        .CHANNELS   (CH),
        .PRE_SHIFT  (PS),
        .COUNT_WIDTH(CW),
        .AW         (AW)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a running channel fires when exactly one period has elapsed
    // since the edge at which it (re)started from zero.
    bit       m_ena [CH];
    bit       m_of  [CH];
    bit       m_dba [CH];
    bit       m_one [CH];
    bit       m_ie  [CH];
    int       m_dr  [CH];
    int       m_start [CH];
    int       cyc;
    logic [7:0] m_rdata;

    function automatic logic [7:0] m_csr(int c);
        return {3'b000, m_ena[c], m_of[c], m_dba[c], m_one[c], m_ie[c]};
    endfunction

    function automatic logic [7:0] m_irq();
        logic [7:0] v;
        v = 8'h00;
        for (int c = 0; c < CH; c++) v[c] = m_ie[c] & m_dba[c];
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_ena[c] = 0; m_of[c] = 0; m_dba[c] = 0;
            m_one[c] = 0; m_ie[c] = 0; m_dr[c] = 0; m_start[c] = 0;
        end
        m_rdata = 8'h00;
    endtask

    task automatic model_edge();
        int  e, a, period;
        bit  tick, wcsr, wdr;
        e = cyc + 1;
        a = int'(addr);
        if (rd_en) begin
            if (a >= 2 * CH)  m_rdata = 8'h00;
            else if (a % 2)   m_rdata = 8'(m_dr[a / 2]);
            else              m_rdata = m_csr(a / 2);
        end
        for (int c = 0; c < CH; c++) begin
            period = (m_dr[c] + 1) << PS;
            tick   = m_ena[c] && (e - m_start[c] == period);
            wcsr   = wr_en && (a == 2 * c);
            wdr    = wr_en && (a == 2 * c + 1);
            if (tick || wdr || (wcsr && wdata[4] && !m_ena[c])) m_start[c] = e;
            if (wcsr && !wdata[3]) m_of[c] = 0;
            if (tick && m_dba[c])  m_of[c] = 1;
            if (wcsr && !wdata[2]) m_dba[c] = 0;
            if (tick)              m_dba[c] = 1;
            if (wcsr) begin
                m_ena[c] = wdata[4];
                m_one[c] = wdata[1];
                m_ie[c]  = wdata[0];
            end else if (tick && m_one[c]) begin
                m_ena[c] = 0;
            end
            if (wdr) m_dr[c] = int'(wdata);
        end
        cyc = e;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit w, input bit r, input int a, input logic [7:0] d);
        wr_en = w;
        rd_en = r;
        addr  = AW'(a);
        wdata = d;
        model_edge();
        @(posedge clock);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("rdata_model", rdata, m_rdata);
        chk("irq_model", {5'b0, irq}, m_irq());
    endtask

    task automatic idle();
        step(0, 0, 0, 8'h00);
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        step(1, 0, a, d);
    endtask

    task automatic rd(input int a);
        step(0, 1, a, 8'h00);
    endtask

    initial begin
        bit         w, r;
        int         a;
        logic [7:0] d;

        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        addr    = '0;
        wdata   = 8'h00;
        cyc     = 0;
        model_reset();
        #12 reset_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            rd(i);
            chk("reset_read", rdata, 8'h00);
        end
        chk("reset_irq", {5'b0, irq}, 8'h00);

        wr(1, 8'd3);
        wr(0, 8'h11);
        repeat (3) idle();
        chk("irq_before_p1", {5'b0, irq}, 8'h00);
        idle();
        chk("irq_at_p1", {5'b0, irq}, 8'h01);
        wr(0, 8'h11);
        chk("irq_sw_clear", {5'b0, irq}, 8'h00);
        repeat (2) idle();
        chk("irq_before_p2", {5'b0, irq}, 8'h00);
        idle();
        chk("irq_at_p2", {5'b0, irq}, 8'h01);
        repeat (4) idle();
        rd(0);
        chk("csr0_of", rdata, 8'h1D);

        repeat (2) idle();
        wr(0, 8'h11);
        chk("irq_tick_vs_clear", {5'b0, irq}, 8'h01);
        rd(0);
        chk("csr0_tick_wins", rdata, 8'h1D);
        wr(0, 8'h00);
        chk("irq_ch0_off", {5'b0, irq}, 8'h00);

        wr(3, 8'd1);
        wr(2, 8'h12);
        repeat (2) idle();
        rd(2);
        chk("oneshot_fire", rdata, 8'h06);
        repeat (20) idle();
        rd(2);
        chk("oneshot_quiet", rdata, 8'h06);
        rd(0);
        chk("ch0_unaffected", rdata, 8'h00);

        wr(6, 8'hFF);
        rd(6);
        chk("oor_read", rdata, 8'h00);
        rd(0);
        chk("oor_no_write", rdata, 8'h00);

        wr(1, 8'd3);
        wr(0, 8'h11);
        rd(1);
        chk("dr0_read", rdata, 8'h03);
        idle();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_rdata", rdata, 8'h00);
        chk("async_rst_irq", {5'b0, irq}, 8'h00);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (10) idle();
        rd(0);
        chk("post_rst_csr0", rdata, 8'h00);
        chk("post_rst_irq", {5'b0, irq}, 8'h00);

        repeat (800) begin
            w = ($urandom % 4) == 0;
            r = ($urandom % 2) == 0;
            a = int'($urandom % 8);
            d = 8'($urandom);
            if (w && (a % 2) == 1) d = 8'($urandom_range(0, 6));
            if (w && (a % 2) == 0 && ($urandom % 3) == 0) d[2] = 1'b1;
            step(w, r, a, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
